// File: rtl/param_sp_ram.sv
// -----------------------------------------------------------------------------
// param_sp_ram
//   Single-port RAM with byte-lane write enables, a selectable read-during-write
//   policy and a power-up clear sweep. After reset the array is zeroed one word
//   per cycle (busy=1, requests ignored), then normal accesses are accepted
//   every cycle.
//
// Parameters
//   DATA_W  : word width, multiple of 8
//   ADDR_W  : address width, DEPTH = 2**ADDR_W
//   RW_MODE : 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE
//
// Ports
//   clock   in   rising-edge clock
//   reset   in   synchronous active-high reset
//   en      in   access request
//   we      in   1 = write, 0 = read (when en=1)
//   be      in   byte-lane write enables, bit i covers data_in[8i+7:8i]
//   addr    in   word address
//   data_in in   write data
//   q       out  registered read data (holds between reads)
//   q_valid out  one-cycle pulse when q was updated
//   busy    out  high during reset and the clear sweep
//
// Configuration
//   PARAM_SP_RAM_OUTREG_EN : adds one output register stage (read latency 2).
// -----------------------------------------------------------------------------
module param_sp_ram #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 6,
   parameter int RW_MODE = 0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  we,
   input  logic [DATA_W/8-1:0]   be,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     data_in,
   output logic [DATA_W-1:0]     q,
   output logic                  q_valid,
   output logic                  busy
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int LANES = DATA_W / 8;

   generate
      if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
         $error("param_sp_ram: DATA_W must be a non-zero multiple of 8");
      end
      if (RW_MODE < 0 || RW_MODE > 2) begin : g_bad_rw_mode
         $error("param_sp_ram: RW_MODE must be 0, 1 or 2");
      end
   endgenerate

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_count;
   logic                r_busy;
   logic [DATA_W-1:0]   r_q;
   logic                r_q_valid;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   logic [DATA_W-1:0]   w_rd_word;
   logic [DATA_W-1:0]   w_merged;

   assign w_rd_word = r_mem[addr];

   // Post-write view of the addressed word, used for WRITE_FIRST readback.
   always_comb begin
      // NOTE: combinational logic uses blocking '=' with a default first, so no latch is inferred.
      w_merged = w_rd_word;
      for (int i = 0; i < LANES; i++) begin
         if (be[i]) w_merged[8*i +: 8] = data_in[8*i +: 8];
      end
   end

   // NOTE: the array itself has no reset; the INIT sweep clears it, which keeps it mappable to RAM.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (r_state == ST_INIT) begin
            r_mem[r_count] <= '0;
         end else if (en && we) begin
            for (int i = 0; i < LANES; i++) begin
               if (be[i]) r_mem[addr][8*i +: 8] <= data_in[8*i +: 8];
            end
         end
      end
   end

   // Control FSM with registered busy and first-stage read data.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= ST_INIT;
         r_count   <= '0;
         r_busy    <= 1'b1;
         r_q       <= '0;
         r_q_valid <= 1'b0;
      end else begin
         r_q_valid <= 1'b0;
         case (r_state)
            ST_INIT: begin
               r_count <= r_count + 1'b1;
               if (r_count == '1) begin
                  r_state <= ST_RUN;
                  r_busy  <= 1'b0;
               end
            end
            ST_RUN: begin
               if (en) begin
                  if (!we) begin
                     r_q       <= w_rd_word;
                     r_q_valid <= 1'b1;
                  end else if (RW_MODE == 0) begin
                     r_q       <= w_rd_word;
                     r_q_valid <= 1'b1;
                  end else if (RW_MODE == 1) begin
                     r_q       <= w_merged;
                     r_q_valid <= 1'b1;
                  end
                  // NO_CHANGE: q holds, no valid pulse on a write.
               end
            end
            default: begin
               r_state <= ST_INIT;
               r_count <= '0;
               r_busy  <= 1'b1;
            end
         endcase
      end
   end

   // Reset is also reflected immediately so busy is high for the whole reset window.
   assign busy = r_busy | reset;

`ifdef PARAM_SP_RAM_OUTREG_EN
   logic [DATA_W-1:0]   r_q_out;
   logic                r_q_valid_out;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_q_out       <= '0;
         r_q_valid_out <= 1'b0;
      end else begin
         r_q_out       <= r_q;
         r_q_valid_out <= r_q_valid;
      end
   end

   assign q       = r_q_out;
   assign q_valid = r_q_valid_out;
`else
   assign q       = r_q;
   assign q_valid = r_q_valid;
`endif

endmodule

// File: tb/tb_param_sp_ram.sv
// -----------------------------------------------------------------------------
// tb_param_sp_ram
//   Drives three instances in parallel from shared inputs:
//     u_m0 : DATA_W=8,  RW_MODE=0 (READ_FIRST)
//     u_m1 : DATA_W=8,  RW_MODE=1 (WRITE_FIRST)
//     u_m2 : DATA_W=16, RW_MODE=2 (NO_CHANGE)
//   A word-array reference model predicts q/q_valid/busy after every edge;
//   directed steps add fixed-value checks for the key scenarios.
// -----------------------------------------------------------------------------
module tb_param_sp_ram;

   localparam int DEPTH = 64;
`ifdef PARAM_SP_RAM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clock;
   logic        reset;
   logic        en;
   logic        we;
   logic [1:0]  be;
   logic [5:0]  addr;
   logic [15:0] din;

   logic [7:0]  q0, q1;
   logic [15:0] q2;
   logic        qv0, qv1, qv2;
   logic        busy0, busy1, busy2;

   int checks = 0;
   int errors = 0;

   // Reference model state (per instance)
   logic [15:0] m_mem [3][DEPTH];
   int          init_left [3];
   logic [15:0] s1q [3];
   logic [15:0] s2q [3];
   logic        s1v [3];
   logic        s2v [3];

   param_sp_ram #(.DATA_W(8), .ADDR_W(6), .RW_MODE(0)) u_m0 (
      .clock(clock), .reset(reset), .en(en), .we(we), .be(be[0:0]),
      .addr(addr), .data_in(din[7:0]), .q(q0), .q_valid(qv0), .busy(busy0)
   );
   param_sp_ram #(.DATA_W(8), .ADDR_W(6), .RW_MODE(1)) u_m1 (
      .clock(clock), .reset(reset), .en(en), .we(we), .be(be[0:0]),
      .addr(addr), .data_in(din[7:0]), .q(q1), .q_valid(qv1), .busy(busy1)
   );
   param_sp_ram #(.DATA_W(16), .ADDR_W(6), .RW_MODE(2)) u_m2 (
      .clock(clock), .reset(reset), .en(en), .we(we), .be(be),
      .addr(addr), .data_in(din), .q(q2), .q_valid(qv2), .busy(busy2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One rising edge of the behavioural model, applied to the sampled inputs.
   task automatic model_edge();
      for (int k = 0; k < 3; k++) begin
         logic [15:0] old_w;
         logic [15:0] new_w;
         int          lanes;
         lanes = (k == 2) ? 2 : 1;
         if (reset) begin
            init_left[k] = DEPTH;
            s1q[k] = '0; s1v[k] = 1'b0;
            s2q[k] = '0; s2v[k] = 1'b0;
         end else begin
            s2q[k] = s1q[k];
            s2v[k] = s1v[k];
            if (init_left[k] > 0) begin
               m_mem[k][DEPTH - init_left[k]] = '0;
               init_left[k] = init_left[k] - 1;
               s1v[k] = 1'b0;
            end else if (en) begin
               old_w = m_mem[k][addr];
               new_w = old_w;
               for (int l = 0; l < lanes; l++)
                  if (be[l]) new_w[8*l +: 8] = din[8*l +: 8];
               if (!we) begin
                  s1q[k] = old_w; s1v[k] = 1'b1;
               end else begin
                  m_mem[k][addr] = new_w;
                  if (k == 0)      begin s1q[k] = old_w; s1v[k] = 1'b1; end
                  else if (k == 1) begin s1q[k] = new_w; s1v[k] = 1'b1; end
                  else             s1v[k] = 1'b0;
               end
            end else begin
               s1v[k] = 1'b0;
            end
         end
      end
   endtask

   function automatic logic [15:0] exp_q(input int k);
      return (LAT == 2) ? s2q[k] : s1q[k];
   endfunction

   function automatic logic exp_v(input int k);
      return (LAT == 2) ? s2v[k] : s1v[k];
   endfunction

   task automatic compare_all();
      check("m0_q",     {24'h0, q0}, {16'h0, exp_q(0)});
      check("m1_q",     {24'h0, q1}, {16'h0, exp_q(1)});
      check("m2_q",     {16'h0, q2}, {16'h0, exp_q(2)});
      check("m0_valid", {31'h0, qv0}, {31'h0, exp_v(0)});
      check("m1_valid", {31'h0, qv1}, {31'h0, exp_v(1)});
      check("m2_valid", {31'h0, qv2}, {31'h0, exp_v(2)});
      check("m0_busy",  {31'h0, busy0}, {31'h0, (reset || init_left[0] > 0)});
      check("m1_busy",  {31'h0, busy1}, {31'h0, (reset || init_left[1] > 0)});
      check("m2_busy",  {31'h0, busy2}, {31'h0, (reset || init_left[2] > 0)});
   endtask

   // Apply inputs at the falling edge, clock once, then compare 1 ns after the rising edge.
   task automatic step(input logic r, input logic e, input logic w, input logic [1:0] b,
                       input logic [5:0] a, input logic [15:0] d);
      reset = r; en = e; we = w; be = b; addr = a; din = d;
      @(posedge clock);
      model_edge();
      #1;
      compare_all();
      @(negedge clock);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 2'b00, 6'd0, 16'h0);
   endtask

   // Run idle cycles until busy drops; returns the number of edges taken.
   task automatic count_sweep(output int n);
      n = 0;
      while (busy0 && n < 200) begin
         idle();
         n++;
      end
   endtask

   initial begin
      int n;
      int idx;
      reset = 1'b1; en = 1'b0; we = 1'b0; be = '0; addr = '0; din = '0;
      for (int k = 0; k < 3; k++) begin
         init_left[k] = DEPTH;
         s1q[k] = '0; s2q[k] = '0; s1v[k] = 1'b0; s2v[k] = 1'b0;
         for (int i = 0; i < DEPTH; i++) m_mem[k][i] = '0;
      end
      @(negedge clock);

      // Reset for two cycles, with a request present to show reset wins.
      step(1'b1, 1'b1, 1'b1, 2'b11, 6'd3, 16'hFFFF);
      step(1'b1, 1'b1, 1'b0, 2'b00, 6'd3, 16'h0);
      check("rst_q",     {24'h0, q0}, 32'h0);
      check("rst_valid", {31'h0, qv0}, 32'h0);
      check("rst_busy",  {31'h0, busy0}, 32'h1);

      // Sweep takes exactly DEPTH cycles; requests during it are ignored by the model too.
      count_sweep(n);
      check("sweep_len", n, DEPTH);

      // Cleared words read back as zero.
      step(1'b0, 1'b1, 1'b0, 2'b00, 6'd0, 16'h0);
      step(1'b0, 1'b1, 1'b0, 2'b00, 6'd63, 16'h0);
      if (LAT == 2) idle();
      check("clr_q63",     {24'h0, q0}, 32'h0);
      check("clr_valid63", {31'h0, qv0}, 32'h1);

      // Write 1,2,3 then read back-to-back.
      step(1'b0, 1'b1, 1'b1, 2'b11, 6'd0, 16'h0001);
      step(1'b0, 1'b1, 1'b1, 2'b11, 6'd1, 16'h0002);
      step(1'b0, 1'b1, 1'b1, 2'b11, 6'd2, 16'h0003);
      idle();
      idle();
      for (int j = 0; j < 5; j++) begin
         if (j < 3) step(1'b0, 1'b1, 1'b0, 2'b00, 6'(j), 16'h0);
         else       idle();
         idx = j - (LAT - 1);
         if (idx >= 0 && idx < 3) begin
            check("seq_q",       {24'h0, q0}, idx + 1);
            check("seq_valid",   {31'h0, qv0}, 32'h1);
            check("seq_q_w16",   {16'h0, q2}, idx + 1);
         end else begin
            check("seq_valid_lo", {31'h0, qv0}, 32'h0);
         end
      end
      check("hold_q", {24'h0, q0}, 32'h3);

      // Read-during-write on addr 1 (holding 2).
      step(1'b0, 1'b1, 1'b1, 2'b01, 6'd1, 16'h0004);
      if (LAT == 2) idle();
      check("rdw_rf_q",     {24'h0, q0}, 32'h2);
      check("rdw_rf_valid", {31'h0, qv0}, 32'h1);
      check("rdw_wf_q",     {24'h0, q1}, 32'h4);
      check("rdw_wf_valid", {31'h0, qv1}, 32'h1);
      check("rdw_nc_q",     {16'h0, q2}, 32'h3);
      check("rdw_nc_valid", {31'h0, qv2}, 32'h0);

      // Byte-lane merge on the 16-bit instance.
      step(1'b0, 1'b1, 1'b1, 2'b11, 6'd5, 16'hAABB);
      step(1'b0, 1'b1, 1'b1, 2'b01, 6'd5, 16'h1122);
      step(1'b0, 1'b1, 1'b1, 2'b00, 6'd5, 16'h5566);
      step(1'b0, 1'b1, 1'b0, 2'b00, 6'd5, 16'h0);
      if (LAT == 2) idle();
      check("be_merge_w16", {16'h0, q2}, 32'hAA22);
      check("be_merge_w8",  {24'h0, q0}, 32'h22);

      // Reset on the cycle after a read request.
      step(1'b0, 1'b1, 1'b0, 2'b00, 6'd1, 16'h0);
      step(1'b1, 1'b1, 1'b0, 2'b00, 6'd1, 16'h0);
      check("rst_rd_q",     {24'h0, q0}, 32'h0);
      check("rst_rd_valid", {31'h0, qv0}, 32'h0);
      check("rst_rd_busy",  {31'h0, busy0}, 32'h1);
      count_sweep(n);
      check("sweep_len2", n, DEPTH);

      // Reset at sweep count 30 restarts the full sweep.
      step(1'b1, 1'b0, 1'b0, 2'b00, 6'd0, 16'h0);
      for (int j = 0; j < 30; j++) step(1'b0, 1'b1, 1'b1, 2'b11, 6'(j), 16'hFFFF);
      step(1'b1, 1'b0, 1'b0, 2'b00, 6'd0, 16'h0);
      check("rst_mid_busy", {31'h0, busy0}, 32'h1);
      check("rst_mid_q",    {24'h0, q0}, 32'h0);
      count_sweep(n);
      check("sweep_len3", n, DEPTH);
      step(1'b0, 1'b1, 1'b0, 2'b00, 6'd1, 16'h0);
      if (LAT == 2) idle();
      check("swept_addr1", {24'h0, q0}, 32'h0);

      // Randomised traffic against the model, with occasional resets.
      for (int j = 0; j < 600; j++) begin
         step(($urandom_range(0, 149) == 0),
              ($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7)),
              16'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
